// File: rtl/disp_msg_scheduler.sv
// Display arbiter for the 4-digit mux: passes stopwatch digits or scrolls a buffered UART message.
// Build option: define DISP_MSG_LOOP_EN to repeat the scroll until abort or reset.
module disp_msg_scheduler #(
  parameter int TICK_DIV  = 12_500_000,
  parameter int MSG_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:0] sw_digits,
  input  logic        wr_valid,
  input  logic [4:0]  wr_data,
  input  logic        wr_last,
  output logic        wr_ready,
  input  logic        abort,
  output logic [5:0]  dig_0,
  output logic [5:0]  dig_1,
  output logic [5:0]  dig_2,
  output logic [5:0]  dig_3,
  output logic        busy
);

  localparam int LEN_W  = $clog2(MSG_DEPTH + 1);
  localparam int POS_W  = $clog2(MSG_DEPTH + 5);
  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int IDX_W  = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FILL   = 2'd1;
  localparam logic [1:0] S_SCROLL = 2'd2;
  localparam logic [5:0] BLANK    = 6'd29;

  logic [1:0]        state;
  logic [LEN_W-1:0]  len;
  logic [POS_W-1:0]  pos;
  logic [TICK_W-1:0] tick;
  logic [4:0]        msg_buf [MSG_DEPTH];

  logic              accept;
  logic              commit;
  logic              last_tick;
  logic              end_frame;
  logic [LEN_W-1:0]  len_nxt;
  logic [IDX_W-1:0]  wr_idx;
  logic [23:0]       frame_p0;

  assign wr_ready  = (state == S_IDLE) || ((state == S_FILL) && (len < LEN_W'(MSG_DEPTH)));
  assign accept    = wr_valid && wr_ready && !abort;
  assign len_nxt   = (state == S_IDLE) ? LEN_W'(1) : len + LEN_W'(1);
  assign commit    = wr_last || (len_nxt == LEN_W'(MSG_DEPTH));
  assign wr_idx    = (state == S_IDLE) ? '0 : IDX_W'(len);
  assign last_tick = (tick == TICK_W'(TICK_DIV - 1));
  assign end_frame = last_tick && (pos == POS_W'(len) + POS_W'(4));

  // Virtual string: four blanks, the message, four blanks.
  function automatic logic [5:0] vchar(input int k, input int n);
    if (k < 4 || k >= 4 + n) return BLANK;
    return {1'b0, msg_buf[IDX_W'(k - 4)]};
  endfunction

  always_ff @(posedge clk) begin
    if (accept) msg_buf[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      len   <= '0;
      pos   <= '0;
      tick  <= '0;
      busy  <= 1'b0;
    end else if (abort) begin
      state <= S_IDLE;
      len   <= '0;
      pos   <= '0;
      tick  <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_FILL: begin
          if (accept) begin
            len <= len_nxt;
            if (commit) begin
              state <= S_SCROLL;
              pos   <= POS_W'(1);
              tick  <= '0;
              busy  <= 1'b1;
            end else begin
              state <= S_FILL;
            end
          end
        end
        S_SCROLL: begin
          if (last_tick) begin
            tick <= '0;
            if (end_frame) begin
`ifdef DISP_MSG_LOOP_EN
              pos <= POS_W'(1);
`else
              state <= S_IDLE;
              busy  <= 1'b0;
              len   <= '0;
              pos   <= '0;
`endif
            end else begin
              pos <= pos + POS_W'(1);
            end
          end else begin
            tick <= tick + TICK_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage p0: frame selected from the current scroll position
  always_comb begin
    frame_p0 = sw_digits;
    if (state == S_SCROLL)
      frame_p0 = {vchar(int'(pos),     int'(len)),
                  vchar(int'(pos) + 1, int'(len)),
                  vchar(int'(pos) + 2, int'(len)),
                  vchar(int'(pos) + 3, int'(len))};
  end

  // Stage p1: registered digits to the display mux
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dig_3 <= BLANK;
      dig_2 <= BLANK;
      dig_1 <= BLANK;
      dig_0 <= BLANK;
    end else begin
      {dig_3, dig_2, dig_1, dig_0} <= frame_p0;
    end
  end

endmodule

// File: tb/tb_disp_msg_scheduler.sv
// Directed bench for disp_msg_scheduler; frame expectations are queued as messages are written.
// Exercises the looping build too when DISP_MSG_LOOP_EN is defined.
module tb_disp_msg_scheduler;

  localparam int TD = 4;
  localparam int MD = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [23:0] sw_digits = '0;
  logic        wr_valid = 1'b0;
  logic [4:0]  wr_data = '0;
  logic        wr_last = 1'b0;
  logic        wr_ready;
  logic        abort = 1'b0;
  logic [5:0]  dig_0, dig_1, dig_2, dig_3;
  logic        busy;
  logic [23:0] digs;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];
  logic [4:0]  msg[$];

  assign digs = {dig_3, dig_2, dig_1, dig_0};

  always #5 clk = ~clk;

  disp_msg_scheduler #(.TICK_DIV(TD), .MSG_DEPTH(MD)) dut (
    .clk(clk), .reset_n(reset_n), .sw_digits(sw_digits),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last), .wr_ready(wr_ready),
    .abort(abort), .dig_0(dig_0), .dig_1(dig_1), .dig_2(dig_2), .dig_3(dig_3), .busy(busy)
  );

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] vch(input int k);
    if (k < 4 || k >= 4 + msg.size()) return 6'd29;
    return {1'b0, msg[k - 4]};
  endfunction

  task automatic push_frames();
    for (int p = 1; p <= msg.size() + 4; p++)
      for (int t = 0; t < TD; t++)
        exp_q.push_back({vch(p), vch(p + 1), vch(p + 2), vch(p + 3)});
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) begin
      step();
      check(tag, digs, exp_q.pop_front());
    end
  endtask

  initial begin
    logic [23:0] sw_a;
    logic [23:0] sw_b;
    sw_a = {6'h21, 6'h02, 6'h03, 6'h04};
    sw_b = {6'h05, 6'h26, 6'h07, 6'h08};

    // reset state
    repeat (2) step();
    check("reset_digits", digs, {4{6'd29}});
    check("reset_busy", busy, 1'b0);
    reset_n = 1'b1;
    sw_digits = sw_a;
    step();
    check("idle_pass", digs, {6'h21, 6'h02, 6'h03, 6'h04});
    check("idle_ready", wr_ready, 1'b1);

    // two-char message, explicit wr_last
    msg = {5'd10, 5'd11};
    wr_valid = 1'b1; wr_data = 5'd10;
    step();
    check("fill_ready", wr_ready, 1'b1);
    check("fill_busy", busy, 1'b0);
    wr_data = 5'd11; wr_last = 1'b1;
    push_frames();
    step();
    wr_valid = 1'b0; wr_last = 1'b0;
    check("scroll_busy", busy, 1'b1);
    check("scroll_ready", wr_ready, 1'b0);
    check("scroll_first_sw", digs, {6'h21, 6'h02, 6'h03, 6'h04});
    drain("scroll2_frame");
    check("scroll2_exit_busy", busy, 1'b0);
    check("scroll2_exit_ready", wr_ready, 1'b1);
    step();
    check("scroll2_back_sw", digs, {6'h21, 6'h02, 6'h03, 6'h04});

    // auto-commit at MSG_DEPTH, codes 30/31 kept, 5th write refused
    msg = {5'd1, 5'd30, 5'd31, 5'd4};
    wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_data = msg[i];
      step();
    end
    push_frames();
    check("auto_busy", busy, 1'b1);
    check("auto_ready", wr_ready, 1'b0);
    wr_data = 5'd7;
    for (int i = 0; i < 3; i++) begin
      step();
      check("auto_frame", digs, exp_q.pop_front());
      check("auto_5th_ready", wr_ready, 1'b0);
    end
    wr_valid = 1'b0;
    drain("auto_frame");
    check("auto_exit_busy", busy, 1'b0);

    // abort during the third frame
    sw_digits = sw_b;
    msg = {5'd10, 5'd11};
    wr_valid = 1'b1; wr_data = 5'd10;
    step();
    wr_data = 5'd11; wr_last = 1'b1;
    step();
    wr_valid = 1'b0; wr_last = 1'b0;
    repeat (9) step();
    check("abort_frame3", digs, {6'd29, 6'd10, 6'd11, 6'd29});
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_ready", wr_ready, 1'b1);
    step();
    check("abort_sw", digs, {6'h05, 6'h26, 6'h07, 6'h08});

    // abort dominates a simultaneous IDLE write
    wr_valid = 1'b1; wr_data = 5'd5; wr_last = 1'b1; abort = 1'b1;
    step();
    wr_valid = 1'b0; wr_last = 1'b0; abort = 1'b0;
    check("abort_wr_busy", busy, 1'b0);
    check("abort_wr_ready", wr_ready, 1'b1);
    wr_valid = 1'b1; wr_data = 5'd6;
    step();
    check("abort_wr_fill", busy, 1'b0);
    wr_data = 5'd7; wr_last = 1'b1;
    step();
    wr_valid = 1'b0; wr_last = 1'b0;
    check("abort_wr_commit", busy, 1'b1);
    step();
    check("abort_wr_frame1", digs, {6'd29, 6'd29, 6'd29, 6'd6});
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_wr_exit", busy, 1'b0);

`ifdef DISP_MSG_LOOP_EN
    // looping scroll of a one-char message
    msg = {5'd9};
    repeat (3) push_frames();
    wr_valid = 1'b1; wr_data = 5'd9; wr_last = 1'b1;
    step();
    wr_valid = 1'b0; wr_last = 1'b0;
    check("loop_busy", busy, 1'b1);
    while (exp_q.size() > 0) begin
      step();
      check("loop_frame", digs, exp_q.pop_front());
      check("loop_busy_hold", busy, 1'b1);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("loop_abort", busy, 1'b0);
`endif

    // asynchronous reset in the middle of a scroll
    wr_valid = 1'b1; wr_data = 5'd12; wr_last = 1'b1;
    step();
    wr_valid = 1'b0; wr_last = 1'b0;
    repeat (3) step();
    check("midreset_pre", busy, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_digits", digs, {4{6'd29}});
    check("midreset_busy", busy, 1'b0);
    check("midreset_ready", wr_ready, 1'b1);
    reset_n = 1'b1;
    step();
    check("midreset_sw", digs, {6'h05, 6'h26, 6'h07, 6'h08});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
